ps2_kbd_matrix: RTL and testbench

Converts a PS/2 keyboard byte stream into the 8×8 key matrix plus modifier lines read by the system's parallel interface (8255-style PPI). Port A output drives `col_sel`, `row_data` feeds port B input, and `mod_n` feeds port C input bits. The block receives PS/2 frames, decodes make/break codes with E0/F0/E1 prefixes, and keeps a registered key-state matrix. The CPU scans that matrix exactly as it would a physical keyboard.

---
 rtl/ps2_kbd_if.sv | 11 +
 rtl/ps2_kbd_matrix.sv | 173 +++++++++++++++++
 tb/tb_ps2_kbd_matrix.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_if.sv
// ps2_kbd_if: PS/2 line inputs plus the PPI-facing matrix scan signals
interface ps2_kbd_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] col_sel;
  logic [7:0] row_data;
  logic [2:0] mod_n;
  logic       frame_err;
  modport master (output ps2_clk, ps2_data, col_sel, input row_data, mod_n, frame_err);
  modport slave  (input ps2_clk, ps2_data, col_sel, output row_data, mod_n, frame_err);
endinterface

// File: rtl/ps2_kbd_matrix.sv
// ps2_kbd_matrix: PS/2 receiver and make/break decoder feeding an 8x8 key matrix
module ps2_kbd_matrix #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input logic       clk,
  input logic       reset_n,
  ps2_kbd_if.slave  bus
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2, S_STOP = 2'd3;
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [63:0]   key_q, key_d;
  logic [4:0]    mods_q, mods_d;
  logic          strike;
  logic [7:0]    m;
  logic [7:0]    row_n;
  // {hit, is_mod, idx}: idx = col*8+row for keys; 0 LShift, 1 RShift, 2 LCtrl, 3 RCtrl, 4 Rus/Lat
  function automatic logic [7:0] kmap(input logic [8:0] k);
    case (k)
      9'h01C: return {2'b10, 6'd17};
      9'h029: return {2'b10, 6'd63};
      9'h05A: return {2'b10, 6'd14};
      9'h175: return {2'b10, 6'd3};
      9'h172: return {2'b10, 6'd4};
      9'h16B: return {2'b10, 6'd1};
      9'h174: return {2'b10, 6'd2};
      9'h015: return {2'b10, 6'd16};
      9'h01D: return {2'b10, 6'd18};
      9'h024: return {2'b10, 6'd19};
      9'h02D: return {2'b10, 6'd20};
      9'h016: return {2'b10, 6'd24};
      9'h01E: return {2'b10, 6'd25};
      9'h026: return {2'b10, 6'd26};
      9'h066: return {2'b10, 6'd13};
      9'h076: return {2'b10, 6'd8};
      9'h00D: return {2'b10, 6'd9};
      9'h012: return {2'b11, 6'd0};
      9'h059: return {2'b11, 6'd1};
      9'h014: return {2'b11, 6'd2};
      9'h114: return {2'b11, 6'd3};
      9'h058: return {2'b11, 6'd4};
      default: return 8'h00;
    endcase
  endfunction
  assign strike = filt_q & ~clk_s2_q & (fcnt_q == FW'(FILTER - 1));
  assign m = kmap({ext_q, sr_q});
  always_comb begin
    filt_d  = filt_q;
    fcnt_d  = '0;
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    wdog_d  = '0;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    key_d   = key_q;
    mods_d  = mods_q;
    if (clk_s2_q != filt_q) begin
      filt_d = (fcnt_q == FW'(FILTER - 1)) ? clk_s2_q : filt_q;
      fcnt_d = (fcnt_q == FW'(FILTER - 1)) ? '0 : fcnt_q + 1'b1;
    end
    if (state_q != S_IDLE) wdog_d = strike ? '0 : wdog_q + 1'b1;
    if (strike) begin
      case (state_q)
        S_IDLE: begin
          ferr_d  = dat_s2_q;
          state_d = dat_s2_q ? S_IDLE : S_DATA;
          bcnt_d  = '0;
        end
        S_DATA: begin
          sr_d    = {dat_s2_q, sr_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          state_d = (bcnt_q == 3'd7) ? S_PAR : S_DATA;
        end
        S_PAR: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          rdy_d   = dat_s2_q & ^{sr_q, par_q};
          ferr_d  = ~(dat_s2_q & ^{sr_q, par_q});
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE && wdog_q == WW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
      wdog_d  = '0;
    end
    if (rdy_q) begin
      if (skip_q != 3'd0) skip_d = skip_q - 1'b1;
      else if (sr_q == 8'hE1) skip_d = 3'd7;
      else if (sr_q == 8'hE0) ext_d = 1'b1;
      else if (sr_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (sr_q == 8'h00 || sr_q == 8'hFF) begin
          key_d  = '0;
          mods_d = '0;
        end else if (m[7] && m[6]) mods_d[m[2:0]] = ~brk_q;
        else if (m[7]) key_d[m[5:0]] = ~brk_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      wdog_q   <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      mods_q   <= '0;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      wdog_q   <= wdog_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
      key_q    <= key_d;
      mods_q   <= mods_d;
    end
  end
  always_comb begin
    row_n = '1;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (key_q[c*8+r] && !bus.col_sel[c]) row_n[r] = 1'b0;
  end
  assign bus.row_data  = row_n;
  assign bus.mod_n     = {~mods_q[4], ~(mods_q[2] | mods_q[3]), ~(mods_q[0] | mods_q[1])};
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// tb_ps2_kbd_matrix: directed byte-table bench plus error, timeout and reset sequences
module tb_ps2_kbd_matrix;
  typedef struct {
    logic       snd;
    logic [7:0] code;
    logic [7:0] col;
    logic [7:0] row;
    logic [2:0] md;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   err_cnt = 0;
  int   e0;
  vec_t tv[$];
  ps2_kbd_if bus();
  ps2_kbd_matrix #(.FILTER(4), .TIMEOUT(400)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.frame_err) err_cnt <= err_cnt + 1;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    cyc(10);
    bus.ps2_clk = 1'b0;
    cyc(20);
    bus.ps2_clk = 1'b1;
    cyc(10);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad);
    ps2_bit(1'b1);
    cyc(30);
  endtask
  task automatic look(input string name, input logic [7:0] col, input logic [7:0] row, input logic [2:0] md);
    bus.col_sel = col;
    #1;
    chk({name, " row"}, 32'(bus.row_data), 32'(row));
    chk({name, " mod"}, 32'(bus.mod_n), 32'(md));
    cyc(1);
  endtask
  task automatic add(input logic s, input logic [7:0] c, input logic [7:0] col, input logic [7:0] row, input logic [2:0] md);
    tv.push_back('{s, c, col, row, md});
  endtask
  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    bus.col_sel = 8'hFF;
    add(1, 8'h1C, 8'hFB, 8'hFD, 3'h7);
    add(0, 8'h00, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'hF0, 8'hFB, 8'hFD, 3'h7);
    add(1, 8'h1C, 8'hFB, 8'hFF, 3'h7);
    add(1, 8'hE0, 8'hFE, 8'hFF, 3'h7);
    add(1, 8'h75, 8'hFE, 8'hF7, 3'h7);
    add(1, 8'h75, 8'hFE, 8'hF7, 3'h7);
    add(1, 8'hE0, 8'hFE, 8'hF7, 3'h7);
    add(1, 8'hF0, 8'hFE, 8'hF7, 3'h7);
    add(1, 8'h75, 8'hFE, 8'hFF, 3'h7);
    add(1, 8'h12, 8'hFF, 8'hFF, 3'h6);
    add(1, 8'h59, 8'hFF, 8'hFF, 3'h6);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h6);
    add(1, 8'h12, 8'hFF, 8'hFF, 3'h6);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h6);
    add(1, 8'h59, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h14, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'hE0, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'h14, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'h14, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'hE0, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h5);
    add(1, 8'h14, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h58, 8'hFF, 8'hFF, 3'h3);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h3);
    add(1, 8'h58, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'hAA, 8'h00, 8'hFF, 3'h7);
    add(1, 8'hE1, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h14, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h77, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'hE1, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h14, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'hF0, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h77, 8'hFF, 8'hFF, 3'h7);
    add(1, 8'h1C, 8'hFB, 8'hFD, 3'h7);
    add(1, 8'h29, 8'h7F, 8'h7F, 3'h7);
    add(1, 8'h5A, 8'h00, 8'h3D, 3'h7);
    add(1, 8'h12, 8'h00, 8'h3D, 3'h6);
    add(1, 8'hFF, 8'h00, 8'hFF, 3'h7);
    cyc(4);
    reset_n = 1'b1;
    cyc(4);
    look("reset", 8'h00, 8'hFF, 3'h7);
    chk("reset frame_err", 32'(bus.frame_err), 32'd0);
    foreach (tv[i]) begin
      if (tv[i].snd) send_byte(tv[i].code, 1'b0);
      look($sformatf("vec%0d", i), tv[i].col, tv[i].row, tv[i].md);
    end
    chk("no frame_err in table", 32'(err_cnt), 32'd0);
    e0 = err_cnt;
    send_byte(8'h29, 1'b1);
    chk("parity err pulse", 32'(err_cnt - e0), 32'd1);
    look("parity no update", 8'h7F, 8'hFF, 3'h7);
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    cyc(500);
    chk("timeout pulse", 32'(err_cnt - e0), 32'd1);
    send_byte(8'h5A, 1'b0);
    look("after timeout", 8'hFD, 8'hBF, 3'h7);
    e0 = err_cnt;
    bus.ps2_clk = 1'b0;
    cyc(2);
    bus.ps2_clk = 1'b1;
    cyc(20);
    chk("glitch ignored", 32'(err_cnt - e0), 32'd0);
    e0 = err_cnt;
    send_byte(8'h1C, 1'b0);
    chk("good frame no err", 32'(err_cnt - e0), 32'd0);
    send_byte(8'h12, 1'b0);
    look("pre reset", 8'h00, 8'hBD, 3'h6);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    reset_n = 1'b0;
    cyc(3);
    look("mid-frame reset", 8'h00, 8'hFF, 3'h7);
    chk("reset frame_err low", 32'(bus.frame_err), 32'd0);
    reset_n = 1'b1;
    cyc(5);
    e0 = err_cnt;
    send_byte(8'h29, 1'b0);
    look("post reset space", 8'h7F, 8'h7F, 3'h7);
    look("post reset enter gone", 8'hFD, 8'hFF, 3'h7);
    chk("post reset no err", 32'(err_cnt - e0), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
